// File: rtl/gray_updown_counter_if.sv
// Control and status bundle for gray_updown_counter.
// The master drives enable/direction/load and the counter (slave) returns the counts and tc.
interface gray_updown_counter_if #(
  parameter int WIDTH = 3
);
  logic             en_i;
  logic             dir_i;
  logic             load_i;
  logic [WIDTH-1:0] load_val_i;
  logic [WIDTH-1:0] count_bin_o;
  logic [WIDTH-1:0] count_gray_o;
  logic             tc_o;

  modport master (
    output en_i, dir_i, load_i, load_val_i,
    input  count_bin_o, count_gray_o, tc_o
  );

  modport slave (
    input  en_i, dir_i, load_i, load_val_i,
    output count_bin_o, count_gray_o, tc_o
  );
endinterface

// File: rtl/gray_updown_counter.sv
// Parametrised up/down counter with registered binary and Gray outputs and a registered tc pulse.
// Define GRAY_UPDOWN_COUNTER_SAT_EN to saturate at 0/MAX instead of wrapping.
module gray_updown_counter #(
  parameter int WIDTH = 3,
  parameter int MAX   = (2**WIDTH)-1
) (
  input logic                 clk,
  input logic                 rst_n,
  gray_updown_counter_if.slave bus
);

  localparam logic [WIDTH-1:0] MaxVal = WIDTH'(MAX);
  localparam logic [WIDTH-1:0] OneVal = WIDTH'(1);

  logic             dirMeta_q;
  logic             dirSync_q;
  logic [WIDTH-1:0] countBin_q;
  logic [WIDTH-1:0] countBin_d;
  logic [WIDTH-1:0] countGray_q;
  logic             tc_q;
  logic             tc_d;

  // dir comes straight from a switch, so it is retimed before it steers the count.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dirMeta_q <= 1'b0;
      dirSync_q <= 1'b0;
    end else begin
      dirMeta_q <= bus.dir_i;
      dirSync_q <= dirMeta_q;
    end
  end

  always_comb begin
    countBin_d = countBin_q;
    tc_d       = 1'b0;
    if (bus.load_i) begin
      countBin_d = (bus.load_val_i > MaxVal) ? MaxVal : bus.load_val_i;
    end else if (bus.en_i) begin
      if (!dirSync_q) begin
        // ">=" also catches an out-of-range state so it can never count further up.
        if (countBin_q >= MaxVal) begin
          tc_d = 1'b1;
`ifdef GRAY_UPDOWN_COUNTER_SAT_EN
          countBin_d = MaxVal;
`else
          countBin_d = '0;
`endif
        end else begin
          countBin_d = countBin_q + OneVal;
        end
      end else begin
        if (countBin_q == '0) begin
          tc_d = 1'b1;
`ifdef GRAY_UPDOWN_COUNTER_SAT_EN
          countBin_d = '0;
`else
          countBin_d = MaxVal;
`endif
        end else begin
          countBin_d = countBin_q - OneVal;
        end
      end
    end
  end

  // Gray is derived from the next binary value so both outputs update on the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      countBin_q  <= '0;
      countGray_q <= '0;
      tc_q        <= 1'b0;
    end else begin
      countBin_q  <= countBin_d;
      countGray_q <= countBin_d ^ (countBin_d >> 1);
      tc_q        <= tc_d;
    end
  end

  assign bus.count_bin_o  = countBin_q;
  assign bus.count_gray_o = countGray_q;
  assign bus.tc_o         = tc_q;

endmodule

// File: tb/tb_gray_updown_counter.sv
// Self-checking bench for gray_updown_counter: a full-modulus (MAX=7) and a MAX=5 instance
// share one stimulus stream and are each compared with a behavioural model.
module tb_gray_updown_counter;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       dir;
  logic       load;
  logic [2:0] loadVal;

  int total = 0;
  int bad   = 0;

  int m7, m5;
  bit t7, t5;
  bit dirQ[$];

  gray_updown_counter_if #(.WIDTH(3)) bus7 ();
  gray_updown_counter_if #(.WIDTH(3)) bus5 ();

  assign bus7.en_i = en;
  assign bus7.dir_i = dir;
  assign bus7.load_i = load;
  assign bus7.load_val_i = loadVal;
  assign bus5.en_i = en;
  assign bus5.dir_i = dir;
  assign bus5.load_i = load;
  assign bus5.load_val_i = loadVal;

  gray_updown_counter #(.WIDTH(3), .MAX(7)) dut7 (.clk(clk), .rst_n(rst_n), .bus(bus7));
  gray_updown_counter #(.WIDTH(3), .MAX(5)) dut5 (.clk(clk), .rst_n(rst_n), .bus(bus5));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Next count from the behavioural rules: load clamps, otherwise step with wrap (or saturate).
  function automatic int modelNext(input int c, input bit e, input bit l, input int lv,
                                   input bit d, input int mx, output bit t);
    t = 1'b0;
    if (l) return (lv > mx) ? mx : lv;
    if (!e) return c;
`ifdef GRAY_UPDOWN_COUNTER_SAT_EN
    if (!d) begin
      if (c >= mx) begin t = 1'b1; return mx; end
      return c + 1;
    end
    if (c == 0) begin t = 1'b1; return 0; end
    return c - 1;
`else
    if (!d) begin
      t = (c >= mx);
      return t ? 0 : c + 1;
    end
    t = (c == 0);
    return t ? mx : c - 1;
`endif
  endfunction

  function automatic int grayOf(input int b);
    return b ^ (b >> 1);
  endfunction

  // One clock edge: direction seen by the counter is the dir present two edges earlier.
  task automatic tick();
    bit effDir;
    bit t;
    @(posedge clk);
    effDir = dirQ.pop_front();
    dirQ.push_back(dir);
    m7 = modelNext(m7, en, load, int'(loadVal), effDir, 7, t);
    t7 = t;
    m5 = modelNext(m5, en, load, int'(loadVal), effDir, 5, t);
    t5 = t;
    #1;
  endtask

  task automatic modelReset();
    m7 = 0; m5 = 0; t7 = 0; t5 = 0;
    dirQ = {};
    dirQ.push_back(1'b0);
    dirQ.push_back(1'b0);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; en = 0; dir = 0; load = 0; loadVal = 0;
    modelReset();
    #12;
    total++;
    if (bus7.count_bin_o !== 3'd0 || bus7.count_gray_o !== 3'd0 || bus7.tc_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset7: bin=%0d gray=%b tc=%b required 0/000/0",
               bus7.count_bin_o, bus7.count_gray_o, bus7.tc_o);
    end
    total++;
    if (bus5.count_bin_o !== 3'd0 || bus5.count_gray_o !== 3'd0 || bus5.tc_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset5: bin=%0d gray=%b tc=%b required 0/000/0",
               bus5.count_bin_o, bus5.count_gray_o, bus5.tc_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_count_up();
    logic [2:0] expBin [9];
    logic [2:0] expGray [9];
    expBin  = '{3'd1, 3'd2, 3'd3, 3'd4, 3'd5, 3'd6, 3'd7, 3'd0, 3'd1};
    expGray = '{3'b001, 3'b011, 3'b010, 3'b110, 3'b111, 3'b101, 3'b100, 3'b000, 3'b001};
    en = 1; dir = 0;
    for (int i = 0; i < 9; i++) begin
      tick();
      total++;
      if (bus7.count_bin_o !== 3'(m7) || bus7.count_gray_o !== 3'(grayOf(m7)) || bus7.tc_o !== t7) begin
        bad++;
        $display("[TB] FAIL count_up7[%0d]: bin=%0d gray=%b tc=%b required %0d/%b/%b",
                 i, bus7.count_bin_o, bus7.count_gray_o, bus7.tc_o, m7, 3'(grayOf(m7)), t7);
      end
`ifndef GRAY_UPDOWN_COUNTER_SAT_EN
      total++;
      if (bus7.count_bin_o !== expBin[i] || bus7.count_gray_o !== expGray[i] ||
          bus7.tc_o !== (i == 7)) begin
        bad++;
        $display("[TB] FAIL count_up_table[%0d]: bin=%0d gray=%b tc=%b required %0d/%b/%b",
                 i, bus7.count_bin_o, bus7.count_gray_o, bus7.tc_o, expBin[i], expGray[i], (i == 7));
      end
`endif
      total++;
      if (bus5.count_bin_o !== 3'(m5) || bus5.tc_o !== t5) begin
        bad++;
        $display("[TB] FAIL count_up5[%0d]: bin=%0d tc=%b required %0d/%b",
                 i, bus5.count_bin_o, bus5.tc_o, m5, t5);
      end
    end
  endtask

  task automatic test_async_reset();
    en = 1; dir = 0;
    repeat (3) tick();
    #3;
    rst_n = 1'b0;
    modelReset();
    #1;
    total++;
    if (bus7.count_bin_o !== 3'd0 || bus7.count_gray_o !== 3'd0 || bus7.tc_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL async_reset: bin=%0d gray=%b tc=%b required 0/000/0",
               bus7.count_bin_o, bus7.count_gray_o, bus7.tc_o);
    end
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    total++;
    if (bus7.count_bin_o !== 3'd1 || bus7.tc_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL reset_release: bin=%0d tc=%b required 1/0",
               bus7.count_bin_o, bus7.tc_o);
    end
  endtask

  task automatic test_dir_change();
    logic [2:0] expBin [7];
    expBin = '{3'd3, 3'd4, 3'd3, 3'd2, 3'd1, 3'd0, 3'd7};
    dir = 0; load = 1; loadVal = 3'd2;
    tick();
    load = 0; en = 1; dir = 1;
    for (int i = 0; i < 7; i++) begin
      tick();
      total++;
      if (bus7.count_bin_o !== 3'(m7) || bus7.count_gray_o !== 3'(grayOf(m7)) || bus7.tc_o !== t7) begin
        bad++;
        $display("[TB] FAIL dir_change7[%0d]: bin=%0d gray=%b tc=%b required %0d/%b/%b",
                 i, bus7.count_bin_o, bus7.count_gray_o, bus7.tc_o, m7, 3'(grayOf(m7)), t7);
      end
      total++;
      if (bus7.count_bin_o !== expBin[i] || bus7.tc_o !== (i == 6)) begin
        bad++;
        $display("[TB] FAIL dir_change_table[%0d]: bin=%0d tc=%b required %0d/%b",
                 i, bus7.count_bin_o, bus7.tc_o, expBin[i], (i == 6));
      end
    end
  endtask

  task automatic test_load();
    en = 0; load = 1; loadVal = 3'd2;
    tick();
    en = 1; loadVal = 3'd5;
    tick();
    total++;
    if (bus7.count_bin_o !== 3'd5 || bus7.count_gray_o !== 3'b111 || bus7.tc_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL load5: bin=%0d gray=%b tc=%b required 5/111/0",
               bus7.count_bin_o, bus7.count_gray_o, bus7.tc_o);
    end
    loadVal = 3'd6;
    tick();
    total++;
    if (bus5.count_bin_o !== 3'd5 || bus7.count_bin_o !== 3'd6) begin
      bad++;
      $display("[TB] FAIL load_clamp: bin5=%0d bin7=%0d required 5/6",
               bus5.count_bin_o, bus7.count_bin_o);
    end
    load = 0; en = 0;
  endtask

  task automatic test_mod5_wrap();
    dir = 0; en = 0; load = 1; loadVal = 3'd5;
    repeat (3) tick();
    load = 0; en = 1;
    tick();
    total++;
    if (bus5.count_bin_o !== 3'(m5) || bus5.count_gray_o !== 3'(grayOf(m5)) || bus5.tc_o !== t5) begin
      bad++;
      $display("[TB] FAIL mod5_up_model: bin=%0d gray=%b tc=%b required %0d/%b/%b",
               bus5.count_bin_o, bus5.count_gray_o, bus5.tc_o, m5, 3'(grayOf(m5)), t5);
    end
`ifndef GRAY_UPDOWN_COUNTER_SAT_EN
    total++;
    if (bus5.count_bin_o !== 3'd0 || bus5.count_gray_o !== 3'b000 || bus5.tc_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mod5_up_wrap: bin=%0d gray=%b tc=%b required 0/000/1",
               bus5.count_bin_o, bus5.count_gray_o, bus5.tc_o);
    end
`endif
    dir = 1; en = 0; load = 1; loadVal = 3'd0;
    repeat (3) tick();
    load = 0; en = 1;
    tick();
    total++;
    if (bus5.count_bin_o !== 3'(m5) || bus5.count_gray_o !== 3'(grayOf(m5)) || bus5.tc_o !== t5) begin
      bad++;
      $display("[TB] FAIL mod5_down_model: bin=%0d gray=%b tc=%b required %0d/%b/%b",
               bus5.count_bin_o, bus5.count_gray_o, bus5.tc_o, m5, 3'(grayOf(m5)), t5);
    end
`ifndef GRAY_UPDOWN_COUNTER_SAT_EN
    total++;
    if (bus5.count_bin_o !== 3'd5 || bus5.count_gray_o !== 3'b111 || bus5.tc_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL mod5_down_wrap: bin=%0d gray=%b tc=%b required 5/111/1",
               bus5.count_bin_o, bus5.count_gray_o, bus5.tc_o);
    end
`endif
    en = 0;
    tick();
    total++;
    if (bus5.tc_o !== 1'b0 || bus5.count_bin_o !== 3'(m5)) begin
      bad++;
      $display("[TB] FAIL hold: bin=%0d tc=%b required %0d/0", bus5.count_bin_o, bus5.tc_o, m5);
    end
  endtask

`ifdef GRAY_UPDOWN_COUNTER_SAT_EN
  task automatic test_saturate();
    dir = 0; en = 0; load = 1; loadVal = 3'd7;
    repeat (3) tick();
    load = 0; en = 1;
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (bus7.count_bin_o !== 3'd7 || bus7.tc_o !== 1'b1) begin
        bad++;
        $display("[TB] FAIL sat_up[%0d]: bin=%0d tc=%b required 7/1", i, bus7.count_bin_o, bus7.tc_o);
      end
    end
    en = 0;
    tick();
    total++;
    if (bus7.tc_o !== 1'b0) begin
      bad++;
      $display("[TB] FAIL sat_idle: tc=%b required 0", bus7.tc_o);
    end
    dir = 1; load = 1; loadVal = 3'd0;
    repeat (3) tick();
    load = 0; en = 1;
    tick();
    total++;
    if (bus7.count_bin_o !== 3'd0 || bus7.tc_o !== 1'b1) begin
      bad++;
      $display("[TB] FAIL sat_down: bin=%0d tc=%b required 0/1", bus7.count_bin_o, bus7.tc_o);
    end
    en = 0;
  endtask
`endif

  task automatic test_random();
    logic [2:0] prevBin;
    logic [2:0] prevGray;
    bit wasLoad;
    for (int i = 0; i < 400; i++) begin
      prevBin  = bus7.count_bin_o;
      prevGray = bus7.count_gray_o;
      en      = ($urandom_range(0, 3) != 0);
      load    = ($urandom_range(0, 15) == 0);
      loadVal = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 9) == 0) dir = ~dir;
      wasLoad = load;
      tick();
      total++;
      if (bus7.count_bin_o !== 3'(m7) || bus7.count_gray_o !== 3'(grayOf(m7)) || bus7.tc_o !== t7) begin
        bad++;
        $display("[TB] FAIL random7[%0d]: bin=%0d gray=%b tc=%b required %0d/%b/%b",
                 i, bus7.count_bin_o, bus7.count_gray_o, bus7.tc_o, m7, 3'(grayOf(m7)), t7);
      end
      total++;
      if (bus5.count_bin_o !== 3'(m5) || bus5.count_gray_o !== 3'(grayOf(m5)) || bus5.tc_o !== t5) begin
        bad++;
        $display("[TB] FAIL random5[%0d]: bin=%0d gray=%b tc=%b required %0d/%b/%b",
                 i, bus5.count_bin_o, bus5.count_gray_o, bus5.tc_o, m5, 3'(grayOf(m5)), t5);
      end
      if (!wasLoad && bus7.count_bin_o !== prevBin) begin
        total++;
        if ($countones(bus7.count_gray_o ^ prevGray) != 1) begin
          bad++;
          $display("[TB] FAIL gray_step[%0d]: %b -> %b required single-bit change",
                   i, prevGray, bus7.count_gray_o);
        end
      end
    end
    load = 0; en = 0;
  endtask

  initial begin
    test_reset();
    test_count_up();
    test_async_reset();
    test_dir_change();
    test_load();
    test_mod5_wrap();
`ifdef GRAY_UPDOWN_COUNTER_SAT_EN
    test_saturate();
`endif
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/gray_updown_counter.md
Name: gray_updown_counter

Overview:
- Parametrised synchronous up/down counter with registered binary and Gray-code outputs.
- Next generation of the team's fixed 3-bit button-driven sequence counters: width, modulus and load are configurable, and direction is synchronised.
- Sits behind pushbutton/switch inputs on the lab boards and drives LED/segment decode logic.

Parameters:
- WIDTH, 3, counter width in bits; legal range 2..16.
- MAX, (2**WIDTH)-1, terminal count (modulus-1); legal range 1..(2**WIDTH)-1.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset.
- en  input  1  count enable, synchronous.
- dir  input  1  direction, asynchronous to clk (0 = up, 1 = down).
- load  input  1  synchronous load strobe.
- load_val  input  WIDTH  value loaded when load=1.
- count_bin  output  WIDTH  registered binary count.
- count_gray  output  WIDTH  registered Gray code of count_bin.
- tc  output  1  terminal-count pulse, registered.

Behaviour:
- Reset: reset=0 forces count_bin=0, count_gray=0, tc=0 and both dir synchroniser flops =0, immediately and independent of clk. This holds while reset is low and applies mid-count.
- Direction: dir passes a 2-flop synchroniser. The effective direction dir_s lags dir by 2 rising edges. A change of dir takes effect on the 3rd edge after it.
- Priority per rising edge: load > en > hold.
- load=1 (en ignored): count_bin <= min(load_val, MAX); tc <= 0.
- en=1, dir_s=0:
  - count_bin==MAX -> 0, tc <= 1.
  - otherwise +1, tc <= 0.
- en=1, dir_s=1:
  - count_bin==0 -> MAX, tc <= 1.
  - otherwise -1, tc <= 0.
- en=0, load=0: count_bin holds; tc <= 0.
- tc is a one-cycle pulse aligned with the wrapped value on count_bin. With en held across several wraps, tc pulses once per wrap.
- count_gray: registered in the same edge as count_bin, equal to next_bin ^ (next_bin >> 1). Both outputs change together, with zero skew between them.
- Latency: en/load sampled at edge N, outputs valid after edge N.
- Arithmetic: internal next-state is WIDTH bits; no overflow beyond MAX is ever stored.
- Out-of-range state (count_bin > MAX, unreachable in normal operation): the next enabled up-count goes to 0 with tc=1; the next enabled down-count decrements normally.
- Gray property:
  - Successive values differ in exactly one bit for every step except wrap, when MAX != 2**WIDTH-1.
  - With full modulus, the wrap step is also single-bit.

Optional Feature:
- Macro: GRAY_UPDOWN_COUNTER_SAT_EN.
- Defined: saturating mode.
  - Up at MAX holds MAX; down at 0 holds 0.
  - tc=1 on every enabled cycle in which the count is blocked at the limit in the current direction; otherwise 0.
  - Load behaviour is unchanged.
- Undefined: wrap-around mode as described in Behaviour.

Test Plan:
- WIDTH=3, MAX=7: counting with en=1, then reset driven 0 asynchronously between edges -> count_bin=0, count_gray=000, tc=0 before the next clk edge. Reset released with en=1, dir=0 -> first edge gives 1.
- WIDTH=3, MAX=7, dir=0, en=1, 9 edges from 0:
  - count_bin = 1,2,3,4,5,6,7,0,1.
  - count_gray = 001,011,010,110,111,101,100,000,001.
  - tc=1 only on the edge producing 0.
- Counting up from 2, dir set to 1 just after an edge -> 2 further up-counts (3,4), then 3,2,1,0,7. tc pulses on 0->7.
- load=1, load_val=5, en=1 at count 2 -> count_bin=5, tc=0.
- Instance MAX=5: load_val=6 -> count_bin=5.
- Instance MAX=5: from 5 up -> 0 with tc=1, count_gray=000. From 0 down -> 5, count_gray=111, tc=1.
- GRAY_UPDOWN_COUNTER_SAT_EN defined, MAX=7:
  - At 7 up, 3 edges -> stays 7, tc=1 each edge.
  - en=0 -> tc=0.
  - dir=1 from 0 -> stays 0, tc=1.
